bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_correct.sv | 32 +++
 rtl/bcd_serial_adder.sv | 149 ++++++++++++++
 tb/tb_bcd_serial_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial BCD adder: controller state encoding and
// the decimal constants used by the digit-correction logic.
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_pkg;

   // Controller states. Kept as plain sized constants so the encoding is fixed
   // and can be compared directly against the exported debug state.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADD  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Largest legal decimal digit, and the adjustment that pushes a binary
   // digit sum above 9 into the next nibble.
   localparam logic [4:0] BCD_MAX = 5'd9;
   localparam logic [4:0] BCD_ADJ = 5'd6;

endpackage

// File: rtl/bcd_digit_correct.sv
// -----------------------------------------------------------------------------
// bcd_digit_correct
// Combinational decimal correction of one binary digit sum.
// Ports:
//   raw   in  [4:0]  binary sum A[i] + B[i] + carry (0..19 for valid digits)
//   digit out [3:0]  corrected decimal digit
//   carry out        decimal carry into the next digit
// -----------------------------------------------------------------------------
module bcd_digit_correct
   import bcd_pkg::*;
(
   input  logic [4:0] raw,
   output logic [3:0] digit,
   output logic       carry
);

   logic [4:0] corr;

   // Adding 6 skips the six unused codes A..F, so the decimal carry lands in
   // bit 4. With invalid input digits the sum may wrap; that result is
   // meaningless anyway and err flags it.
   always_comb begin
      corr = raw;
      if (raw > BCD_MAX) begin
         corr = raw + BCD_ADJ;
      end
   end

   assign digit = corr[3:0];
   assign carry = corr[4];

endmodule

// File: rtl/bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder
// Adds two packed BCD operands one digit per clock, least-significant first,
// using a single shared digit-correction unit.
// Timeline (start sampled at edge 0): edges 1..NDIG each resolve one digit,
// the state enters DONE at edge NDIG, done is raised at edge NDIG+1 and the
// controller returns to IDLE at edge NDIG+2.
// Handshake: start is a request sampled only in IDLE; requests seen while busy
// are dropped, not queued. done is a one-cycle pulse; sum/cout/err are valid
// from done and held until the next accepted start.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a new addition (IDLE only)
//   a, b       in   [4*NDIG-1:0] packed BCD operands, digit 0 in [3:0]
//   cin        in   decimal carry into digit 0
//   busy       out  high in ADD and DONE
//   done       out  one-cycle result-valid pulse
//   sum        out  [4*NDIG-1:0] packed BCD result
//   cout       out  decimal carry out of the top digit
//   err        out  an operand digit latched at start was above 9
//   dbg_state  out  [1:0] controller state, for observation only
// -----------------------------------------------------------------------------
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*NDIG-1:0]   a,
   input  logic [4*NDIG-1:0]   b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [4*NDIG-1:0]   sum,
   output logic                cout,
   output logic                err,
   output logic [1:0]          dbg_state
);

   localparam int W  = 4 * NDIG;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

   state_t          state;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [IW-1:0]   idx;
   logic            carry;

   logic [3:0]      a_dig;
   logic [3:0]      b_dig;
   logic [4:0]      raw;
   logic [3:0]      dig;
   logic            cy;
   logic            bad;

   // Select the digit pair for the current index from the latched operands.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == IW'(i)) begin
            a_dig = op_a[i*4 +: 4];
            b_dig = op_b[i*4 +: 4];
         end
      end
   end

   assign raw = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};

   bcd_digit_correct u_correct (
      .raw   (raw),
      .digit (dig),
      .carry (cy)
   );

   // Invalid-digit scan of the live inputs; only captured on an accepted start.
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (({1'b0, a[i*4 +: 4]} > BCD_MAX) || ({1'b0, b[i*4 +: 4]} > BCD_MAX)) begin
            bad = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         op_a  <= '0;
         op_b  <= '0;
         idx   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= cin;
                  idx   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
                  err   <= bad;
                  state <= ST_ADD;
               end
            end
            ST_ADD: begin
               for (int i = 0; i < NDIG; i++) begin
                  if (idx == IW'(i)) begin
                     sum[i*4 +: 4] <= dig;
                  end
               end
               carry <= cy;
               if (idx == IDX_LAST) begin
                  cout  <= cy;
                  state <= ST_DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            ST_DONE: begin
               // DONE spans two cycles: the result settles in the first, the
               // done pulse is raised for the second, then back to IDLE.
               if (!done) begin
                  done <= 1'b1;
               end else begin
                  done  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state == ST_ADD) || (state == ST_DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_adder
// Directed-vector bench for bcd_serial_adder (NDIG = 4). Expected results are
// hand-computed decimal sums queued at start and popped at the done pulse.
// -----------------------------------------------------------------------------
module tb_bcd_serial_adder;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;
   localparam int LAT  = NDIG + 1;   // edges from start edge to done cycle

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           cin;
   logic           busy;
   logic           done;
   logic [W-1:0]   sum;
   logic           cout;
   logic           err;
   logic [1:0]     dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // {err, cout, sum}
   logic [W+1:0] exp_q[$];

   bcd_serial_adder #(.NDIG(NDIG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Run one addition. Operands are scrambled right after the start edge so a
   // design that keeps reading a/b/cin produces a wrong sum. When only_err is
   // set the sum is don't-care and only err and timing are checked.
   task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_err, input logic only_err);
      logic [W+1:0] e;
      logic [W-1:0] held;
      int n;
      bit got;
      @(negedge clk);
      a     = ta;
      b     = tb;
      cin   = tc;
      start = 1'b1;
      exp_q.push_back({e_err, e_cout, e_sum});
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) got = 1'b1;
      end
      check({tag, "_latency"}, n, LAT);
      check({tag, "_busy_at_done"}, busy, 1);
      e = exp_q.pop_front();
      check({tag, "_err"}, err, e[W+1]);
      if (!only_err) begin
         check({tag, "_sum"}, sum, e[W-1:0]);
         check({tag, "_cout"}, cout, e[W]);
      end
      held = sum;
      @(negedge clk);
      check({tag, "_done_pulse_end"}, done, 0);
      check({tag, "_busy_end"}, busy, 0);
      repeat (2) @(negedge clk);
      check({tag, "_sum_hold"}, sum, held);
      check({tag, "_err_hold"}, err, e[W+1]);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int n_done;
      int first_at;
      int second_at;

      do_reset();
      check("reset_busy",  busy, 0);
      check("reset_done",  done, 0);
      check("reset_sum",   sum, 0);
      check("reset_cout",  cout, 0);
      check("reset_err",   err, 0);
      check("reset_state", dbg_state, 0);

      run_add("t1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
      run_add("t9999_1", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      run_add("tcin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_add("tmax", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0);
      run_add("t0500", 16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      run_add("t4567", 16'h4567, 16'h5433, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      run_add("tbad", 16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      run_add("tclear_err", 16'h0021, 16'h0010, 1'b0, 16'h0031, 1'b0, 1'b0, 1'b0);

      // Second start during ADD with different operands is dropped.
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      n_done = 0;
      first_at = 0;
      repeat (2) begin
         @(posedge clk); n++;
         @(negedge clk); if (done) n_done++;
      end
      a = 16'h7777; b = 16'h8888; cin = 1'b1; start = 1'b1;
      @(posedge clk); n++;
      #1 start = 1'b0;
      @(negedge clk); if (done) n_done++;
      while (n < 14) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (done) begin
            n_done++;
            if (first_at == 0) begin
               first_at = n;
               check("ignore_sum", sum, 16'h3333);
               check("ignore_cout", cout, 0);
            end
         end
      end
      check("ignore_done_count", n_done, 1);
      check("ignore_latency", first_at, LAT);

      // start held high through DONE is taken on the first IDLE cycle, which
      // is two edges after done: second done at 2*LAT + 2 edges.
      @(negedge clk);
      a = 16'h0123; b = 16'h0456; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      n = 0;
      first_at = 0;
      second_at = 0;
      while (n < 20 && second_at == 0) begin
         @(posedge clk); n++;
         if (n == LAT + 2) #1 start = 1'b0;
         @(negedge clk);
         if (done) begin
            if (first_at == 0) first_at = n;
            else second_at = n;
         end
      end
      check("held_first_done", first_at, LAT);
      check("held_second_done", second_at, 2 * LAT + 2);
      check("held_sum", sum, 16'h0579);

      // Reset while digit 2 is being resolved.
      @(negedge clk);
      a = 16'h1234; b = 16'h56F8; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy",  busy, 0);
      check("rst_mid_done",  done, 0);
      check("rst_mid_sum",   sum, 0);
      check("rst_mid_cout",  cout, 0);
      check("rst_mid_err",   err, 0);
      check("rst_mid_state", dbg_state, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      run_add("after_rst", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
